// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store control stage between execute and dmem
// Converts one request at a time into dmem word address, byte enables and lane data.
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] daddr,
  output logic [3:0]            we,
  output logic [DATA_WIDTH-1:0] indata,
  input  logic [DATA_WIDTH-1:0] outdata
);

  typedef enum logic [2:0] {IDLE, STORE, LD_ADDR, LD_WAIT, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(DMEM_DEPTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] daddr_q, daddr_d;
  logic [3:0]            we_q, we_d;
  logic [DATA_WIDTH-1:0] indata_q, indata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;

  logic                  accept;
  logic                  acc_err;
  logic [1:0]            req_size;
  logic [1:0]            req_off;
  logic [DATA_WIDTH-1:0] word_idx;
  logic [3:0]            st_we;
  logic [DATA_WIDTH-1:0] st_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_val;

  assign req_size = req_op[1:0];
  assign req_off  = req_addr[1:0];
  assign word_idx = {2'b00, req_addr[DATA_WIDTH-1:2]};
  assign accept   = (state_q == IDLE) && req_valid;

  // Misalignment, illegal size and out-of-range all short-circuit straight to DONE.
  always_comb begin
    acc_err = 1'b0;
    if (req_size == 2'b11) acc_err = 1'b1;
    if (req_size == 2'b01 && req_off[0]) acc_err = 1'b1;
    if (req_size == 2'b10 && req_off != 2'b00) acc_err = 1'b1;
    if (word_idx >= DEPTH_W) acc_err = 1'b1;
  end

  always_comb begin
    st_we   = 4'hF;
    st_data = req_wdata;
    case (req_size)
      2'b00: begin
        st_we   = 4'b0001 << req_off;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_we   = 4'b0011 << req_off;
        st_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = outdata[{off_q, 3'b000} +: 8];
    ld_half = outdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_val = {{(DATA_WIDTH-8){ld_byte[7] & ~uns_q}}, ld_byte};
      2'b01:   ld_val = {{(DATA_WIDTH-16){ld_half[15] & ~uns_q}}, ld_half};
      default: ld_val = outdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (acc_err)        state_d = DONE;
          else if (req_op[3]) state_d = STORE;
          else                state_d = LD_ADDR;
        end
      end
      STORE:   state_d = DONE;
      LD_ADDR: state_d = LD_WAIT;
      LD_WAIT: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    daddr_d      = daddr_q;
    we_d         = we_q;
    indata_d     = indata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d  = req_off;
          size_d = req_size;
          uns_d  = req_op[2];
          if (acc_err) begin
            we_d         = 4'h0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else if (req_op[3]) begin
            daddr_d  = word_idx;
            we_d     = st_we;
            indata_d = st_data;
          end else begin
            daddr_d = word_idx;
            we_d    = 4'h0;
          end
        end
      end
      STORE: begin
        we_d         = 4'h0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
      end
      LD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = ld_val;
      end
      default: ;
    endcase
  end

  // Async reset also kills an in-flight write enable before the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      daddr_q      <= '0;
      we_q         <= 4'h0;
      indata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
    end else begin
      daddr_q      <= daddr_d;
      we_q         <= we_d;
      indata_q     <= indata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign daddr      = daddr_q;
  assign we         = we_q;
  assign indata     = indata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a behavioural dmem
// Driver pushes expected responses; a negedge monitor pops and compares them.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] daddr;
  logic [3:0]  we;
  logic [31:0] indata;
  logic [31:0] outdata;

  lsu_ctrl #(.DATA_WIDTH(32), .DMEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .daddr(daddr), .we(we), .indata(indata), .outdata(outdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[daddr[9:0]][8*i +: 8] <= indata[8*i +: 8];
    outdata <= mem[daddr[9:0]];
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          tag;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   neg_cnt = 0;
  int   resp_cnt = 0;

  localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010;
  localparam logic [3:0] LBU = 4'b0100, LHU = 4'b0101, BADSZ = 4'b0011;
  localparam logic [3:0] SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (resp_valid === 1'b1) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.nm, " data"}, resp_data, e.data);
          check({e.nm, " err"}, {31'd0, resp_err}, {31'd0, e.err});
          check({e.nm, " lat"}, neg_cnt - e.tag, e.lat);
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] exp_we,
                       input logic [31:0] exp_ind, input logic [31:0] exp_data,
                       input logic exp_err, input int exp_lat);
    int k;
    bit is_st;
    @(negedge clk); #1;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    check({nm, " ready"}, {31'd0, req_ready}, 32'd1);
    exp_q.push_back('{exp_data, exp_err, exp_lat, neg_cnt, nm});
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    is_st = op[3] && !exp_err;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
      if (is_st && k == 1) begin
        check({nm, " we"}, {28'd0, we}, {28'd0, exp_we});
        check({nm, " indata"}, indata, exp_ind);
        check({nm, " daddr"}, daddr, addr >> 2);
      end else begin
        check({nm, " we zero"}, {28'd0, we}, 32'd0);
      end
    end while (!req_ready && k < 10);
    check({nm, " busy"}, k, exp_lat + 1);
  endtask

  initial begin
    int k;
    int p0;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
    k = 0; p0 = 0;
  end

  initial begin
    int k;
    int p0;
    rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst daddr", daddr, 32'd0);
    check("rst we", {28'd0, we}, 32'd0);
    check("rst indata", indata, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    check("rst resp_err", {31'd0, resp_err}, 32'd0);
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;

    issue("sw190", SW, 32'h190, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    issue("lw190", LW, 32'h190, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    issue("sw190b", SW, 32'h190, 32'h11223344, 4'hF, 32'h11223344, 32'h0, 1'b0, 2);
    issue("sb191", SB, 32'h191, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 2);
    issue("lw190c", LW, 32'h190, 32'h0, 4'h0, 32'h0, 32'h1122A544, 1'b0, 3);
    issue("lb191", LB, 32'h191, 32'h0, 4'h0, 32'h0, 32'hFFFFFFA5, 1'b0, 3);
    issue("lbu191", LBU, 32'h191, 32'h0, 4'h0, 32'h0, 32'h000000A5, 1'b0, 3);
    issue("sw1e0", SW, 32'h1E0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0, 2);
    issue("sh1e2", SH, 32'h1E2, 32'h00008001, 4'b1100, 32'h80018001, 32'h0, 1'b0, 2);
    issue("lh1e2", LH, 32'h1E2, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 3);
    issue("lhu1e2", LHU, 32'h1E2, 32'h0, 4'h0, 32'h0, 32'h00008001, 1'b0, 3);
    issue("lw1e0", LW, 32'h1E0, 32'h0, 4'h0, 32'h0, 32'h80010000, 1'b0, 3);

    issue("err lw191", LW, 32'h191, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1);
    issue("err lh1e3", LH, 32'h1E3, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1);
    issue("err size11", BADSZ, 32'h190, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1);
    issue("err sw oor", SW, 32'h1000, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0, 1'b1, 1);
    issue("err sh191", SH, 32'h191, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1);
    issue("rb190", LW, 32'h190, 32'h0, 4'h0, 32'h0, 32'h1122A544, 1'b0, 3);
    issue("rb1e0", LW, 32'h1E0, 32'h0, 4'h0, 32'h0, 32'h80010000, 1'b0, 3);

    // req_valid held high across two stores
    @(negedge clk); #1;
    p0 = resp_cnt;
    req_op = SW; req_addr = 32'h300; req_wdata = 32'h11111111; req_valid = 1'b1;
    check("hold a ready", {31'd0, req_ready}, 32'd1);
    exp_q.push_back('{32'h0, 1'b0, 2, neg_cnt, "hold a"});
    @(posedge clk); #1;
    req_addr = 32'h304; req_wdata = 32'h22222222;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
      if (!req_ready) check("hold busy valid", {31'd0, req_valid}, 32'd1);
    end while (!req_ready && k < 10);
    check("hold a busy", k, 3);
    exp_q.push_back('{32'h0, 1'b0, 2, neg_cnt, "hold b"});
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!req_ready && k < 10);
    check("hold b busy", k, 3);
    check("hold pulses", resp_cnt - p0, 2);
    issue("rb300", LW, 32'h300, 32'h0, 4'h0, 32'h0, 32'h11111111, 1'b0, 3);
    issue("rb304", LW, 32'h304, 32'h0, 4'h0, 32'h0, 32'h22222222, 1'b0, 3);

    // reset in the middle of a STORE cycle
    issue("sw200", SW, 32'h200, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    @(negedge clk); #1;
    req_op = SW; req_addr = 32'h200; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort we pre", {28'd0, we}, 32'hF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort we", {28'd0, we}, 32'd0);
    check("abort ready", {31'd0, req_ready}, 32'd1);
    check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort daddr", daddr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue("rb200", LW, 32'h200, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 3);

    repeat (4) @(negedge clk);
    check("queue drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
